// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and FSM state encoding for the ALU sequencer
package alu_pkg;

    localparam int OP_W   = 2;
    localparam int OPND_W = 3;
    localparam int RES_W  = 6;
    localparam int CMD_W  = OP_W + 2 * OPND_W;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESULT = 2'b11
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - DEPTH-entry command queue of packed {op,a,b} words
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push is refused while full even if a pop happens in the same cycle
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - queues ALU commands and runs them one at a time; ALU_SEQ_TIMEOUT_EN adds a WAIT watchdog
module alu_seq
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    output logic              alu_init,
    output logic [OP_W-1:0]   alu_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [OP_W-1:0]   res_op,
    output logic              res_err,
    output logic              busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CMD_W-1:0]       fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   capture;
    logic                   tmo_hit;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_op, cmd_a, cmd_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign res_valid = (state == ST_RESULT);
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        alu_init  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_init  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESULT;
                end else if (tmo_hit) begin
                    state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands are loaded on pop and held until the next pop, covering ISSUE through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            res_data <= '0;
            res_op   <= '0;
        end else begin
            if (fifo_pop) begin
                {alu_op, alu_a, alu_b} <= fifo_rdata;
            end
            if (capture) begin
                res_data <= alu_out;
                res_op   <= alu_op;
            end else if (tmo_hit) begin
                res_data <= '0;
                res_op   <= alu_op;
            end
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_WAIT) && !alu_done && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            res_err <= 1'b0;
        end else begin
            tmo_cnt <= ((state == ST_WAIT) && !alu_done) ? tmo_cnt + 1'b1 : '0;
            if (capture) begin
                res_err <= 1'b0;
            end else if (tmo_hit) begin
                res_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign res_err        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized scoreboard bench for alu_seq with a behavioural ALU responder
module tb_alu_seq;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [OPND_W-1:0] cmd_a;
    logic [OPND_W-1:0] cmd_b;
    logic              alu_init;
    logic [OP_W-1:0]   alu_op;
    logic [OPND_W-1:0] alu_a;
    logic [OPND_W-1:0] alu_b;
    logic              alu_done;
    logic [RES_W-1:0]  alu_out;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic [OP_W-1:0]   res_op;
    logic              res_err;
    logic              busy;

    always #5 clk = ~clk;

    alu_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_init  (alu_init),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_done  (alu_done),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_err   (res_err),
        .busy      (busy)
    );

    typedef struct {
        int op;
        int a;
        int b;
        int data;
        int err;
    } item_t;

    item_t exp_res[$];
    item_t exp_iss[$];

    int checks = 0;
    int errors = 0;
    int init_count = 0;
    int results = 0;
    int alu_lat = 3;
    bit alu_never = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) & 63;
            1:       return (a - b) & 63;
            2:       return (a * b) & 63;
            default: return (b == 0) ? 63 : a / b;
        endcase
    endfunction

    // ALU responder: answers each init alu_lat cycles later unless alu_never is set
    int m_op, m_a, m_b;
    initial begin
        alu_done = 1'b0;
        alu_out  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && alu_init && !alu_never) begin
                m_op = alu_op;
                m_a  = alu_a;
                m_b  = alu_b;
                repeat (alu_lat) @(posedge clk);
                #1;
                alu_done = 1'b1;
                alu_out  = RES_W'(ref_alu(m_op, m_a, m_b));
                @(posedge clk);
                #1;
                alu_done = 1'b0;
                alu_out  = RES_W'($urandom);
            end
        end
    end

    // Issue monitor: operands and ordering at every init pulse
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (rst_n && alu_init) begin
                init_count++;
                check("init_while_result", res_valid, 1'b0);
                if (exp_iss.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL init_unexpected: got init with no pending command, required none");
                end else begin
                    check("init_after_prev_result", exp_res.size(), exp_iss.size());
                    e = exp_iss.pop_front();
                    check("init_operands", {alu_op, alu_a, alu_b}, {e.op[1:0], e.a[2:0], e.b[2:0]});
                end
            end
        end
    end

    // Result monitor: stability under backpressure and in-order comparison on handshake
    initial begin
        item_t      e;
        bit         stalled = 1'b0;
        logic [8:0] held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", res_valid, 1'b1);
                    check("hold_payload", {res_data, res_op, res_err}, held);
                end
                if (res_valid && res_ready) begin
                    results++;
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL result_unexpected: got data %0d with empty scoreboard", res_data);
                    end else begin
                        e = exp_res.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_op", res_op, e.op);
                        check("res_err", res_err, e.err);
                    end
                end
                stalled = res_valid && !res_ready;
                held    = {res_data, res_op, res_err};
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic try_cmd(input int op, input int a, input int b, output bit acc);
        item_t e;
        cmd_valid = 1'b1;
        cmd_op    = OP_W'(op);
        cmd_a     = OPND_W'(a);
        cmd_b     = OPND_W'(b);
        @(negedge clk);
        acc = cmd_ready;
        if (acc) begin
            e.op   = op;
            e.a    = a;
            e.b    = b;
            e.data = alu_never ? 0 : ref_alu(op, a, b);
            e.err  = alu_never ? 1 : 0;
            exp_iss.push_back(e);
            exp_res.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input int op, input int a, input int b);
        bit acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            try_cmd(op, a, b, acc);
            if (!acc) res_ready = 1'b1;
        end
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic drain(input string tag, input int budget);
        res_ready = 1'b1;
        for (int i = 0; i < budget && exp_res.size() != 0; i++) step(1);
        check({tag, "_drained"}, exp_res.size(), 0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_alu_init"}, alu_init, 1'b0);
        check({tag, "_alu_operands"}, {alu_op, alu_a, alu_b}, 0);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_payload"}, {res_data, res_op, res_err}, 0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        bit   acc;
        int   n_acc;
        int   n0;
        int   seen;
        logic a1, a2;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        // Single command with exact issue latency
        alu_lat = 3;
        try_cmd(0, 2, 5, acc);
        check("single_accept", acc, 1'b1);
        @(negedge clk);
        a1 = alu_init;
        @(posedge clk);
        @(negedge clk);
        a2 = alu_init;
        step(1);
        check("init_latency", {a1, a2}, 2'b01);
        n0 = results;
        drain("single", 50);
        check("single_results", results - n0, 1);

        // Back-to-back commands
        n0 = results;
        send(0, 2, 5);
        send(1, 6, 3);
        send(2, 3, 3);
        drain("b2b", 100);
        check("b2b_results", results - n0, 3);

        // Full queue: 4 queued plus 1 in flight, rest refused
        res_ready = 1'b0;
        alu_lat   = 2;
        n_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            try_cmd(i & 3, i + 1, 7 - i, acc);
            n_acc += acc;
        end
        check("full_accepted", n_acc, 5);
        check("full_ready_low", cmd_ready, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            try_cmd(1, 7, 1, acc);
            n_acc += acc;
        end
        check("full_refused", n_acc, 0);
        drain("full", 300);

        // Backpressure: result held 10 cycles with a command waiting behind it
        res_ready = 1'b0;
        alu_lat   = 3;
        send(1, 6, 3);
        send(2, 3, 3);
        seen = 0;
        for (int i = 0; i < 50 && !res_valid; i++) step(1);
        check("bp_valid_seen", res_valid, 1'b1);
        n0 = init_count;
        step(10);
        check("bp_no_new_init", init_count, n0);
        check("bp_still_valid", res_valid, 1'b1);
        drain("bp", 100);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            alu_lat   = $urandom_range(1, 5);
            if ($urandom_range(0, 2) == 0) step(1);
            send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
        end
        drain("random", 1000);

`ifdef ALU_SEQ_TIMEOUT_EN
        // ALU never answers: error result after TIMEOUT wait cycles
        alu_never = 1'b1;
        res_ready = 1'b1;
        send(3, 5, 2);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = alu_init;
        end
        check("tmo_init_seen", seen, 1);
        n0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n0++;
            if (res_valid) break;
        end
        check("tmo_wait_cycles", n0, TIMEOUT + 1);
        step(1);
        drain("tmo", 50);
        alu_never = 1'b0;
        send(0, 4, 3);
        drain("tmo_next", 50);
`endif

        // Reset in WAIT with two commands queued
        alu_lat   = 8;
        res_ready = 1'b1;
        n0        = init_count;
        send(2, 7, 7);
        send(0, 1, 1);
        send(1, 5, 4);
        for (int i = 0; i < 20 && init_count == n0; i++) step(1);
        check("rst_first_issued", init_count - n0, 1);
        step(2);
        check("rst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_res.delete();
        exp_iss.delete();
        step(2);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid || alu_init) seen++;
            step(1);
        end
        check("post_reset_quiet", seen, 0);
        check("post_reset_busy", busy, 1'b0);
        alu_lat = 3;
        n0      = results;
        send(3, 7, 2);
        drain("post_reset", 50);
        check("post_reset_results", results - n0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
